// File: rtl/dmem_arbiter_if.sv
// Bundle of requester and data-memory signals shared by dmem_arbiter.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  ioReq0_valid;
    logic                  ioReq0_ready;
    logic                  ioReq0_writeEn;
    logic                  ioReq0_readEn;
    logic                  ioReq0_isSigned;
    logic [1:0]            ioReq0_dataLen;
    logic [ADDR_WIDTH-1:0] ioReq0_addr;
    logic [DATA_WIDTH-1:0] ioReq0_dataIn;
    logic                  ioReq0_respValid;
    logic [DATA_WIDTH-1:0] ioReq0_dataOut;

    logic                  ioReq1_valid;
    logic                  ioReq1_ready;
    logic                  ioReq1_writeEn;
    logic                  ioReq1_readEn;
    logic                  ioReq1_isSigned;
    logic [1:0]            ioReq1_dataLen;
    logic [ADDR_WIDTH-1:0] ioReq1_addr;
    logic [DATA_WIDTH-1:0] ioReq1_dataIn;
    logic                  ioReq1_respValid;
    logic [DATA_WIDTH-1:0] ioReq1_dataOut;

    logic                  ioDMem_ready;
    logic                  ioDMem_writeEn;
    logic                  ioDMem_readEn;
    logic                  ioDMem_isSigned;
    logic [1:0]            ioDMem_dataLen;
    logic [ADDR_WIDTH-1:0] ioDMem_addr;
    logic [DATA_WIDTH-1:0] ioDMem_dataIn;
    logic [DATA_WIDTH-1:0] ioDMem_dataOut;

    modport slave (
        input  ioReq0_valid, ioReq0_writeEn, ioReq0_readEn, ioReq0_isSigned,
               ioReq0_dataLen, ioReq0_addr, ioReq0_dataIn,
        output ioReq0_ready, ioReq0_respValid, ioReq0_dataOut,
        input  ioReq1_valid, ioReq1_writeEn, ioReq1_readEn, ioReq1_isSigned,
               ioReq1_dataLen, ioReq1_addr, ioReq1_dataIn,
        output ioReq1_ready, ioReq1_respValid, ioReq1_dataOut,
        input  ioDMem_ready, ioDMem_dataOut,
        output ioDMem_writeEn, ioDMem_readEn, ioDMem_isSigned,
               ioDMem_dataLen, ioDMem_addr, ioDMem_dataIn
    );

    modport master (
        output ioReq0_valid, ioReq0_writeEn, ioReq0_readEn, ioReq0_isSigned,
               ioReq0_dataLen, ioReq0_addr, ioReq0_dataIn,
        input  ioReq0_ready, ioReq0_respValid, ioReq0_dataOut,
        output ioReq1_valid, ioReq1_writeEn, ioReq1_readEn, ioReq1_isSigned,
               ioReq1_dataLen, ioReq1_addr, ioReq1_dataIn,
        input  ioReq1_ready, ioReq1_respValid, ioReq1_dataOut,
        output ioDMem_ready, ioDMem_dataOut,
        input  ioDMem_writeEn, ioDMem_readEn, ioDMem_isSigned,
               ioDMem_dataLen, ioDMem_addr, ioDMem_dataIn
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the data-memory port (accept / issue / respond, round-robin).
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 always win contention.
//
//   state | meaning
//   IDLE  | waiting for a request; winner accepted combinationally
//   ISSUE | latched request driven to memory until ioDMem_ready
//   RESP  | one-cycle respValid pulse to the owner
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  io
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e                state_q;
    logic                  owner_q;
    logic                  we_q;
    logic                  re_q;
    logic                  signed_q;
    logic [1:0]            len_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [1:0]            resp_valid_q;
    logic [DATA_WIDTH-1:0] dout0_q;
    logic [DATA_WIDTH-1:0] dout1_q;

    logic                  any_valid;
    logic                  win_port;
    logic                  accept;
    logic                  sel_we;
    logic                  sel_re;
    logic                  sel_signed;
    logic [1:0]            sel_len;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;
    logic [DATA_WIDTH-1:0] rdata;

    assign any_valid = io.ioReq0_valid | io.ioReq1_valid;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign win_port = ~io.ioReq0_valid;
`else
    logic rr_ptr_q;
    assign win_port = io.ioReq1_valid & (~io.ioReq0_valid | rr_ptr_q);
`endif

    // Ready is masked by reset so nothing is accepted in a reset cycle.
    assign accept = (state_q == IDLE) && !reset && any_valid;
    assign io.ioReq0_ready = accept && !win_port;
    assign io.ioReq1_ready = accept && win_port;

    assign sel_we     = win_port ? io.ioReq1_writeEn  : io.ioReq0_writeEn;
    assign sel_re     = win_port ? io.ioReq1_readEn   : io.ioReq0_readEn;
    assign sel_signed = win_port ? io.ioReq1_isSigned : io.ioReq0_isSigned;
    assign sel_len    = win_port ? io.ioReq1_dataLen  : io.ioReq0_dataLen;
    assign sel_addr   = win_port ? io.ioReq1_addr     : io.ioReq0_addr;
    assign sel_din    = win_port ? io.ioReq1_dataIn   : io.ioReq0_dataIn;

    assign rdata = re_q ? io.ioDMem_dataOut : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= 1'b0;
`endif
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            signed_q     <= 1'b0;
            len_q        <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            resp_valid_q <= '0;
            dout0_q      <= '0;
            dout1_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        owner_q  <= win_port;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        rr_ptr_q <= ~win_port;
`endif
                        // Enables are registered so memory sees them only while in ISSUE.
                        we_q     <= sel_we;
                        re_q     <= sel_re & ~sel_we;
                        signed_q <= sel_signed;
                        len_q    <= sel_len;
                        addr_q   <= sel_addr;
                        din_q    <= sel_din;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (io.ioDMem_ready) begin
                        we_q     <= 1'b0;
                        re_q     <= 1'b0;
                        signed_q <= 1'b0;
                        len_q    <= '0;
                        addr_q   <= '0;
                        din_q    <= '0;
                        resp_valid_q[owner_q] <= 1'b1;
                        if (owner_q) dout1_q <= rdata;
                        else         dout0_q <= rdata;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= '0;
                    dout0_q      <= '0;
                    dout1_q      <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.ioDMem_writeEn   = we_q;
    assign io.ioDMem_readEn    = re_q;
    assign io.ioDMem_isSigned  = signed_q;
    assign io.ioDMem_dataLen   = len_q;
    assign io.ioDMem_addr      = addr_q;
    assign io.ioDMem_dataIn    = din_q;
    assign io.ioReq0_respValid = resp_valid_q[0];
    assign io.ioReq1_respValid = resp_valid_q[1];
    assign io.ioReq0_dataOut   = dout0_q;
    assign io.ioReq1_dataOut   = dout1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        logic          valid;
        logic          we;
        logic          re;
        logic          sg;
        logic [1:0]    len;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } req_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    req_t          rq[2];
    logic          mem_ready;
    logic [DW-1:0] mem_data;

    // Model: at most one transaction in flight, described by m_txn.
    bit            m_busy;
    bit            m_resp;
    int            m_owner;
    int            m_pref;
    req_t          m_txn;
    logic [DW-1:0] m_rdata;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    bit rec = 0;
    int grants[$];
    int gcyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic req_t idle_req();
        req_t r;
        r.valid = 0; r.we = 0; r.re = 0; r.sg = 0; r.len = 0; r.addr = 0; r.din = 0;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.valid = 1'($urandom_range(0, 1));
        r.we    = 1'($urandom_range(0, 1));
        r.re    = 1'($urandom_range(0, 1));
        r.sg    = 1'($urandom_range(0, 1));
        r.len   = 2'($urandom_range(0, 3));
        r.addr  = $urandom;
        r.din   = $urandom;
        return r;
    endfunction

    function automatic int model_winner();
        if (!rq[0].valid && !rq[1].valid) return -1;
        if (rq[0].valid && !rq[1].valid) return 0;
        if (!rq[0].valid && rq[1].valid) return 1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return m_pref;
`endif
    endfunction

    task automatic apply();
        bus.ioReq0_valid    = rq[0].valid;  bus.ioReq1_valid    = rq[1].valid;
        bus.ioReq0_writeEn  = rq[0].we;     bus.ioReq1_writeEn  = rq[1].we;
        bus.ioReq0_readEn   = rq[0].re;     bus.ioReq1_readEn   = rq[1].re;
        bus.ioReq0_isSigned = rq[0].sg;     bus.ioReq1_isSigned = rq[1].sg;
        bus.ioReq0_dataLen  = rq[0].len;    bus.ioReq1_dataLen  = rq[1].len;
        bus.ioReq0_addr     = rq[0].addr;   bus.ioReq1_addr     = rq[1].addr;
        bus.ioReq0_dataIn   = rq[0].din;    bus.ioReq1_dataIn   = rq[1].din;
        bus.ioDMem_ready    = mem_ready;
        bus.ioDMem_dataOut  = mem_data;
    endtask

    task automatic check_outputs();
        int   w;
        bit   issuing;
        logic exp_we, exp_re;
        w = model_winner();
        issuing = m_busy && !m_resp;
        exp_we = issuing && m_txn.we;
        exp_re = issuing && m_txn.re && !m_txn.we;
        chk("ready0", bus.ioReq0_ready, 64'(!reset && !m_busy && w == 0));
        chk("ready1", bus.ioReq1_ready, 64'(!reset && !m_busy && w == 1));
        chk("mem_we", bus.ioDMem_writeEn, 64'(exp_we));
        chk("mem_re", bus.ioDMem_readEn, 64'(exp_re));
        chk("mem_signed", bus.ioDMem_isSigned, issuing ? 64'(m_txn.sg) : 64'd0);
        chk("mem_len", bus.ioDMem_dataLen, issuing ? 64'(m_txn.len) : 64'd0);
        chk("mem_addr", bus.ioDMem_addr, issuing ? 64'(m_txn.addr) : 64'd0);
        chk("mem_din", bus.ioDMem_dataIn, issuing ? 64'(m_txn.din) : 64'd0);
        chk("resp0", bus.ioReq0_respValid, 64'(m_resp && m_owner == 0));
        chk("resp1", bus.ioReq1_respValid, 64'(m_resp && m_owner == 1));
        chk("dout0", bus.ioReq0_dataOut, (m_resp && m_owner == 0) ? 64'(m_rdata) : 64'd0);
        chk("dout1", bus.ioReq1_dataOut, (m_resp && m_owner == 1) ? 64'(m_rdata) : 64'd0);
        if (rec && bus.ioReq0_ready === 1'b1) begin grants.push_back(0); gcyc.push_back(cyc); end
        if (rec && bus.ioReq1_ready === 1'b1) begin grants.push_back(1); gcyc.push_back(cyc); end
    endtask

    task automatic model_step();
        int w;
        if (reset) begin
            m_busy = 0; m_resp = 0; m_pref = 0;
        end else if (m_resp) begin
            m_busy = 0; m_resp = 0;
        end else if (m_busy) begin
            if (mem_ready) begin
                m_resp  = 1;
                m_rdata = (m_txn.re && !m_txn.we) ? mem_data : '0;
            end
        end else begin
            w = model_winner();
            if (w >= 0) begin
                m_busy  = 1;
                m_txn   = rq[w];
                m_owner = w;
                m_pref  = 1 - w;
            end
        end
    endtask

    task automatic tick();
        apply();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_step();
        cyc++;
        #1;
    endtask

    initial begin
        rq[0] = idle_req();
        rq[1] = idle_req();
        mem_ready = 1'b1;
        mem_data  = '0;
        m_busy = 0; m_resp = 0; m_pref = 0; m_owner = 0; m_rdata = '0;
        m_txn = idle_req();
        reset = 1'b1;
        apply();
        @(posedge clock);
        #1;

        // Reset values, with requests present but masked by reset.
        rq[0].valid = 1; rq[1].valid = 1;
        tick();
        rq[0] = idle_req(); rq[1] = idle_req();
        tick();
        reset = 1'b0;

        // Single read on port 0.
        rq[0].valid = 1; rq[0].re = 1; rq[0].len = 2'd3; rq[0].addr = 32'h8000_0010;
        mem_data = 32'hDEAD_BEEF;
        tick();
        rq[0] = idle_req();
        tick();
        mem_data = 32'h0BAD_F00D;
        tick();
        chk("single_read_dout", 64'(m_rdata), 64'hDEAD_BEEF);
        tick();

        // Contention from reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rec = 1;
        for (int i = 0; i < 12; i++) begin
            rq[0] = rand_req(); rq[0].valid = 1;
            rq[1] = rand_req(); rq[1].valid = 1;
            mem_data = $urandom;
            tick();
        end
        rec = 0;
        chk("grant_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size(); i++) begin
            int exp_g;
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            chk("grant_port", 64'(grants[i]), 64'(exp_g));
            if (i > 0) chk("grant_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
        end
        rq[0] = idle_req(); rq[1] = idle_req();
        repeat (3) tick();

        // Port 1 write with a 3-cycle memory stall.
        rq[1].valid = 1; rq[1].we = 1; rq[1].len = 2'd3;
        rq[1].addr = 32'h8000_0100; rq[1].din = 32'h1234_5678;
        tick();
        rq[1] = idle_req();
        mem_ready = 1'b0;
        repeat (3) begin
            mem_data = $urandom;
            tick();
        end
        mem_ready = 1'b1;
        tick();
        tick();
        tick();

        // Write takes priority over read.
        rq[0].valid = 1; rq[0].we = 1; rq[0].re = 1; rq[0].len = 2'd2;
        rq[0].addr = 32'h8000_0040; rq[0].din = 32'hCAFE_0001;
        tick();
        rq[0] = idle_req();
        repeat (3) tick();

        // Reset while port 0's read is in ISSUE, then contention prefers port 0.
        rq[0].valid = 1; rq[0].re = 1; rq[0].addr = 32'h8000_0200; rq[0].len = 2'd3;
        tick();
        rq[0] = idle_req();
        mem_ready = 1'b0;
        tick();
        reset = 1'b1;
        mem_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        rq[0] = rand_req(); rq[0].valid = 1;
        rq[1] = rand_req(); rq[1].valid = 1;
        apply();
        #1;
        chk("post_reset_pref0", 64'(bus.ioReq0_ready), 64'd1);
        tick();
        rq[0] = idle_req(); rq[1] = idle_req();
        repeat (3) tick();

        // No-op request on port 1.
        rq[1].valid = 1; rq[1].addr = 32'h8000_0300; rq[1].din = 32'hFFFF_FFFF;
        mem_data = 32'h5555_AAAA;
        tick();
        rq[1] = idle_req();
        repeat (3) tick();

        // Random traffic with stalls and occasional resets.
        for (int i = 0; i < 400; i++) begin
            rq[0] = rand_req();
            rq[1] = rand_req();
            mem_ready = ($urandom_range(0, 9) < 7);
            mem_data  = $urandom;
            reset     = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;
        rq[0] = idle_req(); rq[1] = idle_req();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
